// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode codes, burst
// FSM states and the single-step next-value function.
package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SHL  = 3'd1;
  localparam logic [2:0] MODE_SHR  = 3'd2;
  localparam logic [2:0] MODE_ROL  = 3'd3;
  localparam logic [2:0] MODE_ROR  = 3'd4;
  localparam logic [2:0] MODE_LOAD = 3'd5;

  // Widest register the shared function can operate on.
  localparam int MAX_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } burst_state_e;

  // One operation on a w-bit value held in the low bits of a MAX_W vector.
  // Codes 6 and 7 fall through to HOLD.
  function automatic logic [MAX_W-1:0] next_q(
    input logic [2:0]       op,
    input logic [MAX_W-1:0] q,
    input logic             sin_lsb,
    input logic             sin_msb,
    input logic [MAX_W-1:0] d,
    input int unsigned      w
  );
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] qm;
    logic [MAX_W-1:0] top_bit;
    logic [MAX_W-1:0] low_bit;
    // For w == MAX_W the shift yields zero and the subtraction wraps to all ones.
    mask    = (MAX_W'(1) << w) - MAX_W'(1);
    qm      = q & mask;
    top_bit = (qm >> (w - 1)) & MAX_W'(1);
    low_bit = qm & MAX_W'(1);
    case (op)
      MODE_SHL:  next_q = ((qm << 1) | MAX_W'(sin_lsb)) & mask;
      MODE_SHR:  next_q = (qm >> 1) | (MAX_W'(sin_msb) << (w - 1));
      MODE_ROL:  next_q = ((qm << 1) | top_bit) & mask;
      MODE_ROR:  next_q = (qm >> 1) | (low_bit << (w - 1));
      MODE_LOAD: next_q = d & mask;
      default:   next_q = qm;
    endcase
  endfunction

endpackage

// File: rtl/shift_burst_ctrl.sv
// Burst controller: decides on which edges the register steps and with which op.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | single-step via en, or accept a start request
//   ST_BUSY | burst running: latched op applied every edge, rem counts down
module shift_burst_ctrl
  import shift_reg_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             apply_o,
  output logic [2:0]       op_o,
  output logic             busy_o,
  output logic             done_o
);

  burst_state_e     state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [2:0]       op_q, op_d;
  logic             done_q, done_d;

  // State, remaining count, latched op and completion pulse; reset aborts any burst.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      op_q    <= MODE_HOLD;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; the first burst operation happens on the accepting edge.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    op_d    = op_q;
    done_d  = 1'b0;
    apply_o = 1'b0;
    op_o    = mode_i;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          op_d = mode_i;
          if (count_i == '0) begin
            rem_d  = '0;
            done_d = 1'b1;
          end else begin
            apply_o = 1'b1;
            rem_d   = count_i - CNT_W'(1);
            if (count_i == CNT_W'(1)) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_BUSY;
            end
          end
        end else if (en_i) begin
          apply_o = 1'b1;
        end
      end
      ST_BUSY: begin
        apply_o = 1'b1;
        op_o    = op_q;
        rem_d   = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o = (state_q == ST_BUSY);
  assign done_o = done_q;

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register with burst engine; holds q and exposes serial taps
// so instances can be chained.
module universal_shift_register
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter int               CNT_W   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic             sin_lsb_i,
  input  logic             sin_msb_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] count_i,
  output logic [WIDTH-1:0] q_o,
  output logic             sout_msb_o,
  output logic             sout_lsb_o,
  output logic             busy_o,
  output logic             done_o
);

  logic             apply;
  logic [2:0]       op;
  logic [WIDTH-1:0] q_q, q_d;

  shift_burst_ctrl #(
    .CNT_W(CNT_W)
  ) u_ctrl (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (en_i),
    .mode_i  (mode_i),
    .start_i (start_i),
    .count_i (count_i),
    .apply_o (apply),
    .op_o    (op),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  // Step the register only on edges the controller marks as applying.
  always_comb begin
    q_d = q_q;
    if (apply) begin
      q_d = WIDTH'(next_q(op, MAX_W'(q_q), sin_lsb_i, sin_msb_i, MAX_W'(d_i), WIDTH));
    end
  end

  // Register contents with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o        = q_q;
  assign sout_msb_o = q_q[WIDTH-1];
  assign sout_lsb_o = q_q[0];

endmodule
